// File: rtl/mem_pkg.sv
// Shared definitions for the load/store memory path: handshake FSM states,
// latency limits and the word/byte-enable types used by data_ram.
package mem_pkg;

    // Largest supported request-to-response latency in cycles.
    localparam int MEM_LAT_MAX = 4;

    // Basic data-path types.
    typedef logic [31:0] word_t;
    typedef logic [3:0]  be_t;

    // Wide enough to hold LATENCY-2 for every latency up to MEM_LAT_MAX.
    typedef logic [1:0]  lat_cnt_t;

    // Responder handshake states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } mem_state_e;

endpackage

// File: rtl/data_ram_array.sv
// DEPTH x 32-bit storage with per-byte synchronous write enables and a
// synchronous read port. The read register only loads on a read strobe,
// so it holds the captured word until the response is presented.
// Contents are never reset.
module data_ram_array
    import mem_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic          re_i,
    input  logic [AW-1:0] index_i,
    input  logic [3:0]    be_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    word_t mem_r [DEPTH];
    word_t rdata_r;

    // Byte-lane writes commit at the edge the write is accepted.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int n = 0; n < 4; n++) begin
                if (be_i[n]) begin
                    mem_r[index_i][8*n +: 8] <= wdata_i[8*n +: 8];
                end
            end
        end
    end

    // Read word is captured at the acceptance edge and held until the next read.
    always_ff @(posedge clk) begin
        if (re_i) begin
            rdata_r <= mem_r[index_i];
        end
    end

    assign rdata_o = rdata_r;

endmodule

// File: rtl/data_ram.sv
// data_ram: data-memory responder for the core's mem stage.
// Accepts one word-aligned read/write at a time over req/gnt and returns
// exactly one rvalid pulse LATENCY cycles after acceptance.
// Build option: define DATA_RAM_ERR_EN to enable the alignment/range check
// (illegal requests then answer with err_o=1, rdata_o=0 and never write).
// Without it every request is legal, addr_i[1:0] is ignored and the word
// index wraps modulo DEPTH.
module data_ram
    import mem_pkg::*;
#(
    parameter int          DEPTH     = 1024,
    parameter int          LATENCY   = 1,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    localparam int       AW       = $clog2(DEPTH);
    // Counter preload so that BUSY lasts LATENCY-1 cycles.
    localparam lat_cnt_t LAT_LOAD = lat_cnt_t'((LATENCY > 1) ? (LATENCY - 2) : 0);

    mem_state_e     state_r;
    lat_cnt_t       cnt_r;
    logic           gnt_r;
    logic           rvalid_r;
    logic           err_r;
    logic           pend_err_r;
    logic           pend_rd_r;

    logic [31:0]    offset_s;
    logic [AW-1:0]  index_s;
    logic           legal_s;
    logic           accept_s;
    logic           arr_we_s;
    logic           arr_re_s;
    logic [31:0]    arr_rdata_s;

    assign offset_s = addr_i - BASE_ADDR;
    assign index_s  = offset_s[AW+1:2];

`ifdef DATA_RAM_ERR_EN
    // Word aligned and inside the array window.
    assign legal_s = (offset_s[1:0] == 2'b00) && (offset_s[31:2] < 30'(DEPTH));
`else
    // Out-of-range addresses wrap and the byte offset is ignored.
    assign legal_s = 1'b1;
    logic unused_addr_s;
    assign unused_addr_s = ^{offset_s[31:AW+2], offset_s[1:0]};
`endif

    assign accept_s = req_i && gnt_r;
    assign arr_we_s = accept_s && we_i && legal_s;
    assign arr_re_s = accept_s && !we_i && legal_s;

    data_ram_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk     (clk),
        .we_i    (arr_we_s),
        .re_i    (arr_re_s),
        .index_i (index_s),
        .be_i    (be_i),
        .wdata_i (wdata_i),
        .rdata_o (arr_rdata_s)
    );

    // Handshake FSM with latency counter; all outputs registered from next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            cnt_r      <= 2'd0;
            gnt_r      <= 1'b1;
            rvalid_r   <= 1'b0;
            err_r      <= 1'b0;
            pend_err_r <= 1'b0;
            pend_rd_r  <= 1'b0;
        end else begin
            // Attributes of the accepted request, needed when its response goes out.
            if (accept_s) begin
                pend_err_r <= ~legal_s;
                pend_rd_r  <= ~we_i & legal_s;
            end

            case (state_r)
                IDLE, RESP: begin
                    if (accept_s) begin
                        if (LATENCY == 1) begin
                            state_r  <= RESP;
                            gnt_r    <= 1'b1;
                            rvalid_r <= 1'b1;
                            err_r    <= ~legal_s;
                        end else begin
                            state_r  <= BUSY;
                            cnt_r    <= LAT_LOAD;
                            gnt_r    <= 1'b0;
                            rvalid_r <= 1'b0;
                            err_r    <= 1'b0;
                        end
                    end else begin
                        state_r  <= IDLE;
                        gnt_r    <= 1'b1;
                        rvalid_r <= 1'b0;
                        err_r    <= 1'b0;
                    end
                end
                BUSY: begin
                    if (cnt_r == 2'd0) begin
                        state_r  <= RESP;
                        gnt_r    <= 1'b1;
                        rvalid_r <= 1'b1;
                        err_r    <= pend_err_r;
                    end else begin
                        state_r  <= BUSY;
                        cnt_r    <= cnt_r - 2'd1;
                        gnt_r    <= 1'b0;
                        rvalid_r <= 1'b0;
                        err_r    <= 1'b0;
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    cnt_r    <= 2'd0;
                    gnt_r    <= 1'b1;
                    rvalid_r <= 1'b0;
                    err_r    <= 1'b0;
                end
            endcase
        end
    end

    assign gnt_o    = gnt_r;
    assign rvalid_o = rvalid_r;
    assign err_o    = err_r;
    // Read data only appears with the response of a legal read; otherwise zero.
    assign rdata_o  = (rvalid_r && pend_rd_r) ? arr_rdata_s : 32'h0000_0000;

endmodule

// File: tb/tb_data_ram.sv
// Directed self-checking bench for data_ram. Three instances run side by
// side with LATENCY 1, 2 and 3; each directed step drives one instance.
module tb_data_ram;

    logic        clk = 1'b0;
    logic        rst;
    logic        req   [3];
    logic        we    [3];
    logic [31:0] addr  [3];
    logic [3:0]  be    [3];
    logic [31:0] wdata [3];
    logic        gnt   [3];
    logic        rvalid[3];
    logic [31:0] rdata [3];
    logic        err   [3];

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        data_ram #(
            .DEPTH     (1024),
            .LATENCY   (g + 1),
            .BASE_ADDR (32'h0000_0000)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .req_i    (req[g]),
            .gnt_o    (gnt[g]),
            .we_i     (we[g]),
            .addr_i   (addr[g]),
            .be_i     (be[g]),
            .wdata_i  (wdata[g]),
            .rvalid_o (rvalid[g]),
            .rdata_o  (rdata[g]),
            .err_o    (err[g])
        );
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int k, input logic w, input logic [31:0] a,
                         input logic [3:0] b, input logic [31:0] d);
        req[k]   = 1'b1;
        we[k]    = w;
        addr[k]  = a;
        be[k]    = b;
        wdata[k] = d;
    endtask

    // One complete transaction with bounded waits for grant and response.
    task automatic txn(input int k, input logic w, input logic [31:0] a,
                       input logic [3:0] b, input logic [31:0] d,
                       output logic [31:0] rd, output logic e);
        logic got;
        drive(k, w, a, b, d);
        got = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (gnt[k] === 1'b1) begin
                got = 1'b1;
                break;
            end
            step();
        end
        check("gnt_wait", 32'(got), 32'd1);
        step();
        req[k] = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (rvalid[k] === 1'b1) begin
                got = 1'b1;
                break;
            end
            step();
        end
        check("rvalid_wait", 32'(got), 32'd1);
        rd = rdata[k];
        e  = err[k];
        step();
    endtask

    initial begin
        logic [31:0] rd;
        logic        e;
        logic [31:0] vals [4];

        vals[0] = 32'hA0A0_0001;
        vals[1] = 32'hB1B1_0002;
        vals[2] = 32'hC2C2_0003;
        vals[3] = 32'hD3D3_0004;

        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req[k] = 1'b0; we[k] = 1'b0; addr[k] = 32'h0; be[k] = 4'h0; wdata[k] = 32'h0;
        end
        step();
        step();

        // Reset values of every instance
        for (int k = 0; k < 3; k++) begin
            check("rst_gnt",    32'(gnt[k]),    32'd1);
            check("rst_rvalid", 32'(rvalid[k]), 32'd0);
            check("rst_rdata",  rdata[k],       32'h0);
            check("rst_err",    32'(err[k]),    32'd0);
        end
        rst = 1'b0;
        step();

        // LATENCY=1: write then read back-to-back
        drive(0, 1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF);
        check("A_gnt_idle", 32'(gnt[0]), 32'd1);
        step();
        check("A_wr_rvalid", 32'(rvalid[0]), 32'd1);
        check("A_wr_rdata",  rdata[0],       32'h0);
        check("A_wr_err",    32'(err[0]),    32'd0);
        drive(0, 1'b0, 32'h10, 4'h0, 32'h0);
        step();
        check("A_rd_rvalid", 32'(rvalid[0]), 32'd1);
        check("A_rd_rdata",  rdata[0],       32'hDEAD_BEEF);
        check("A_rd_err",    32'(err[0]),    32'd0);
        req[0] = 1'b0;
        step();
        check("A_idle_rvalid", 32'(rvalid[0]), 32'd0);
        check("A_idle_rdata",  rdata[0],       32'h0);

        // LATENCY=3: full write, partial write, read back
        drive(2, 1'b1, 32'h20, 4'hF, 32'h1122_3344);
        step();
        req[2] = 1'b0;
        check("B_busy1_gnt",    32'(gnt[2]),    32'd0);
        check("B_busy1_rvalid", 32'(rvalid[2]), 32'd0);
        step();
        check("B_busy2_gnt",    32'(gnt[2]),    32'd0);
        check("B_busy2_rvalid", 32'(rvalid[2]), 32'd0);
        step();
        check("B_w1_rvalid", 32'(rvalid[2]), 32'd1);
        check("B_w1_gnt",    32'(gnt[2]),    32'd1);
        check("B_w1_rdata",  rdata[2],       32'h0);
        drive(2, 1'b1, 32'h20, 4'b0101, 32'hAABB_CCDD);
        step();
        req[2] = 1'b0;
        check("B_w2_busy_rvalid", 32'(rvalid[2]), 32'd0);
        check("B_w2_busy_gnt",    32'(gnt[2]),    32'd0);
        step();
        step();
        check("B_w2_rvalid", 32'(rvalid[2]), 32'd1);
        drive(2, 1'b0, 32'h20, 4'h0, 32'h0);
        step();
        req[2] = 1'b0;
        step();
        check("B_rd_early_rvalid", 32'(rvalid[2]), 32'd0);
        step();
        check("B_rd_rvalid", 32'(rvalid[2]), 32'd1);
        check("B_rd_rdata",  rdata[2],       32'h11BB_33DD);
        check("B_rd_err",    32'(err[2]),    32'd0);
        step();
        check("B_after_rvalid", 32'(rvalid[2]), 32'd0);

        // LATENCY=2: preload four words, then four reads with req held high
        for (int i = 0; i < 4; i++) begin
            txn(1, 1'b1, 32'h40 + 32'(4 * i), 4'hF, vals[i], rd, e);
            check("C_wr_err", 32'(e), 32'd0);
        end
        drive(1, 1'b0, 32'h40, 4'h0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("C_busy_gnt",    32'(gnt[1]),    32'd0);
            check("C_busy_rvalid", 32'(rvalid[1]), 32'd0);
            if (i < 3) addr[1] = 32'h40 + 32'(4 * (i + 1));
            else       req[1]  = 1'b0;
            step();
            check("C_resp_rvalid", 32'(rvalid[1]), 32'd1);
            check("C_resp_rdata",  rdata[1],       vals[i]);
        end
        step();
        check("C_end_rvalid", 32'(rvalid[1]), 32'd0);

        // Reset while a LATENCY=3 read is in BUSY
        drive(2, 1'b0, 32'h20, 4'h0, 32'h0);
        step();
        req[2] = 1'b0;
        check("D_busy_gnt", 32'(gnt[2]), 32'd0);
        #2 rst = 1'b1;
        #1;
        check("D_rst_gnt",    32'(gnt[2]),    32'd1);
        check("D_rst_rvalid", 32'(rvalid[2]), 32'd0);
        check("D_rst_rdata",  rdata[2],       32'h0);
        check("D_rst_err",    32'(err[2]),    32'd0);
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("D_no_resp", 32'(rvalid[2]), 32'd0);
        end
        txn(2, 1'b0, 32'h20, 4'h0, 32'h0, rd, e);
        check("D_kept_rdata", rd, 32'h11BB_33DD);

`ifdef DATA_RAM_ERR_EN
        // Legality checks enabled
        txn(0, 1'b1, 32'h0, 4'hF, 32'hCAFE_F00D, rd, e);
        check("E_w0_err", 32'(e), 32'd0);
        txn(0, 1'b0, 32'h13, 4'h0, 32'h0, rd, e);
        check("E_mis_err",   32'(e), 32'd1);
        check("E_mis_rdata", rd,     32'h0);
        txn(0, 1'b1, 32'h1000, 4'hF, 32'h1234_5678, rd, e);
        check("E_oor_err",   32'(e), 32'd1);
        check("E_oor_rdata", rd,     32'h0);
        txn(0, 1'b0, 32'h0, 4'h0, 32'h0, rd, e);
        check("E_w0_rdata", rd,     32'hCAFE_F00D);
        check("E_w0_rerr",  32'(e), 32'd0);
`else
        // Wrapping addresses, byte offset ignored
        txn(0, 1'b1, 32'h1000, 4'hF, 32'h5A5A_5A5A, rd, e);
        check("E_wrap_werr", 32'(e), 32'd0);
        txn(0, 1'b0, 32'h0, 4'h0, 32'h0, rd, e);
        check("E_wrap_rdata", rd,     32'h5A5A_5A5A);
        check("E_wrap_rerr",  32'(e), 32'd0);
        txn(0, 1'b0, 32'h13, 4'h0, 32'h0, rd, e);
        check("E_mis_rdata", rd,     32'hDEAD_BEEF);
        check("E_mis_err",   32'(e), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
